// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes and the command-master state encoding.
`default_nettype none
`timescale 1ns/1ps

package axil_pkg;

    localparam logic [1:0] AXIL_OKAY   = 2'b00;
    localparam logic [1:0] AXIL_EXOKAY = 2'b01;
    localparam logic [1:0] AXIL_SLVERR = 2'b10;
    localparam logic [1:0] AXIL_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4,
        ST_RSP     = 3'd5
    } axil_mst_state_t;

endpackage

`default_nettype wire

// File: rtl/axil_cmd_master.sv
// ============================================================================
// axil_cmd_master: single-outstanding AXI4-Lite initiator driven by a local
// command/response handshake. Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module axil_cmd_master
    import axil_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [STRB_W-1:0] cmd_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic [ADDR_W-1:0] axil_awaddr,
    output logic [2:0]        axil_awprot,
    output logic              axil_awvalid,
    input  logic              axil_awready,
    output logic [DATA_W-1:0] axil_wdata,
    output logic [STRB_W-1:0] axil_wstrb,
    output logic              axil_wvalid,
    input  logic              axil_wready,
    input  logic [1:0]        axil_bresp,
    input  logic              axil_bvalid,
    output logic              axil_bready,
    output logic [ADDR_W-1:0] axil_araddr,
    output logic [2:0]        axil_arprot,
    output logic              axil_arvalid,
    input  logic              axil_arready,
    input  logic [DATA_W-1:0] axil_rdata,
    input  logic [1:0]        axil_rresp,
    input  logic              axil_rvalid,
    output logic              axil_rready
);

    axil_mst_state_t   state_q, state_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic              arvalid_q, arvalid_d;
    logic              bready_q, bready_d;
    logic              rready_q, rready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        resp_q, resp_d;
    logic              aw_hs, w_hs;

    assign aw_hs = awvalid_q && axil_awready;
    assign w_hs  = wvalid_q && axil_wready;

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        arvalid_d   = arvalid_q;
        bready_d    = bready_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        resp_d      = resp_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    write_d = cmd_write;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wstrb_d = cmd_wstrb;
                    if (cmd_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = ST_WR_REQ;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = ST_RD_REQ;
                    end
                end
            end
            ST_WR_REQ: begin
                // AW and W retire independently; proceed once both have been seen.
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    bready_d = 1'b1;
                    state_d  = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (axil_bvalid) begin
                    bready_d    = 1'b0;
                    resp_d      = axil_bresp;
                    rdata_d     = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RSP;
                end
            end
            ST_RD_REQ: begin
                if (axil_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD_RESP;
                end
            end
            ST_RD_RESP: begin
                if (axil_rvalid) begin
                    rready_d    = 1'b0;
                    rdata_d     = axil_rdata;
                    resp_d      = axil_rresp;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RSP;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                awvalid_d   = 1'b0;
                wvalid_d    = 1'b0;
                arvalid_d   = 1'b0;
                bready_d    = 1'b0;
                rready_d    = 1'b0;
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            resp_q      <= '0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            resp_q      <= resp_d;
        end
    end

    // Local-side ready only; gated by rst so it reads low throughout reset.
    assign cmd_ready    = (state_q == ST_IDLE) && !rst;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_write    = write_q;
    assign rsp_rdata    = rdata_q;
    assign rsp_resp     = resp_q;
    assign axil_awaddr  = addr_q;
    assign axil_awprot  = 3'b000;
    assign axil_awvalid = awvalid_q;
    assign axil_wdata   = wdata_q;
    assign axil_wstrb   = wstrb_q;
    assign axil_wvalid  = wvalid_q;
    assign axil_bready  = bready_q;
    assign axil_araddr  = addr_q;
    assign axil_arprot  = 3'b000;
    assign axil_arvalid = arvalid_q;
    assign axil_rready  = rready_q;

endmodule

`default_nettype wire
